// File: rtl/result_reader.sv
// result_reader: drains the multiplier result RAM after the compute controller
// finishes. On an accepted start it reads addresses 0 .. count-1, one word at
// a time, and presents each word on a valid/ready stream. A one-cycle done
// pulse follows acceptance of the final word.
module result_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Largest burst the RAM can hold; larger requests are clamped to this.
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t              state_reg;
    // One bit wider than the RAM address so a full-depth burst never wraps.
    logic [ADDR_W:0]     addr_reg;
    logic [ADDR_W:0]     cnt_reg;
    logic                rd_en_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                out_valid_reg;
    logic                out_last_reg;
    logic                busy_reg;
    logic                done_reg;

    // Clamped request count and the next address, used on state transitions.
    logic [ADDR_W:0]     count_clamped;
    logic [ADDR_W:0]     addr_next;

    // Clamp the requested count and precompute the following address.
    always_comb begin
        count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
        addr_next     = addr_reg + 1'b1;
    end

    // Burst controller; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cnt_reg  <= count_clamped;
                        addr_reg <= '0;
                        busy_reg <= 1'b1;
                        if (count_clamped == '0) begin
                            // Nothing to drain: report completion straight away.
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ST_READ;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= '0;
                        end
                    end
                end

                ST_READ: begin
                    // The read was issued this cycle; data returns next cycle.
                    state_reg <= ST_WAIT;
                    rd_en_reg <= 1'b0;
                end

                ST_WAIT: begin
                    state_reg     <= ST_PRESENT;
                    out_data_reg  <= rd_data;
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= (addr_next == cnt_reg);
                end

                ST_PRESENT: begin
                    // out_data_reg is untouched here, so it holds under backpressure.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (out_last_reg) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ST_READ;
                            addr_reg    <= addr_next;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= addr_next[ADDR_W-1:0];
                        end
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    rd_en_reg     <= 1'b0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en     = rd_en_reg;
    assign rd_addr   = rd_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: drives result_reader against a registered-read RAM model
// and checks each burst against the expected word list ram[0 .. n-1].
module tb_result_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Result RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h1000_0000 + i;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    endtask

    // mode: 0 ready always high, 1 random ready, 2 stall word 1 for 5 cycles.
    // repulse: cycle at which a stray start (count=1) is pulsed, -1 for none.
    // rst_at: word index during whose presentation reset is applied, -1 for none.
    task automatic run_burst(input int cnt, input int mode, input int repulse, input int rst_at);
        int   n, idx, rd_cnt, first_v, last_acc, stall;
        logic rdy, fin;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        idx = 0; rd_cnt = 0; first_v = -1; last_acc = -1; stall = 0; fin = 1'b0;
        chk("idle_busy", busy, 1'b0);
        start = 1'b1;
        count = cnt[ADDR_W:0];
        @(negedge clk);
        for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
            start = (cyc == repulse);
            if (cyc == repulse) count = 1;
            chk("busy", busy, 1'b1);
            if (rd_en) begin
                rd_cnt++;
                chk("rd_addr", rd_addr, idx);
                chk("rd_en_vs_valid", out_valid, 1'b0);
            end
            rdy = (mode == 1) ? 1'($urandom % 2) : 1'b1;
            if (out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("first_valid_latency", cyc, 3);
                end
                if (idx >= n) begin
                    chk("extra_word", idx, n);
                end else begin
                    chk("out_data", out_data, ram[idx]);
                    chk("out_last", out_last, (idx == n - 1));
                end
                if (idx == rst_at) begin
                    rst = 1'b1;
                    out_ready = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_rd_en", rd_en, 1'b0);
                    chk("rst_rd_addr", rd_addr, 0);
                    chk("rst_out_data", out_data, 0);
                    chk("rst_out_valid", out_valid, 1'b0);
                    chk("rst_out_last", out_last, 1'b0);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    $display("burst count=%0d reset at word %0d", cnt, idx);
                    return;
                end
                if (mode == 2 && idx == 1 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end
                if (rdy) begin
                    last_acc = cyc;
                    idx++;
                end
            end else begin
                chk("out_last_idle", out_last, 1'b0);
            end
            out_ready = rdy;
            if (done) begin
                chk("words_before_done", idx, n);
                chk("done_timing", cyc, (n == 0) ? 1 : last_acc + 1);
                fin = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("burst_completed", fin, 1'b1);
        chk("done_single_pulse", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("read_count", rd_cnt, n);
        $display("burst count=%0d mode=%0d words=%0d reads=%0d", cnt, mode, idx, rd_cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b1;
        fill_ramp();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rd_en", rd_en, 1'b0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_burst(5, 0, -1, 2);     // reset mid-burst
        run_burst(2, 0, -1, -1);    // recovery after reset
        run_burst(4, 0, -1, -1);    // basic drain
        run_burst(3, 2, -1, -1);    // backpressure on word 1
        run_burst(0, 0, -1, -1);    // zero count
        run_burst(16, 0, -1, -1);   // full depth
        run_burst(31, 0, -1, -1);   // clamp
        run_burst(4, 0, 4, -1);     // start ignored while busy

        for (int r = 0; r < 16; r++) begin
            fill_random();
            run_burst(int'($urandom_range(0, 31)), 1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Drains the multiplier's result RAM after the compute controller asserts done.
- On a start pulse, issues sequential synchronous reads from address 0 for a latched word count.
- Presents each word on a valid/ready output stream, then pulses done.
- Acts as the read side of the result RAM that the compute controller writes via wr_ram.

Parameters:
- DATA_W, 32, result word width; matches the result RAM data width.
- ADDR_W, 4, result RAM address width; maximum count is 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin draining; honoured only in IDLE.
- count  input  ADDR_W+1  number of words to read; sampled on an accepted start.
- rd_en  output  1  result RAM read enable.
- rd_addr  output  ADDR_W  result RAM read address.
- rd_data  input  DATA_W  result RAM read data; valid the cycle after rd_en.
- out_data  output  DATA_W  current output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word when high together with out_valid.
- out_last  output  1  current word is the final word of the burst.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (synchronous, rst high at a rising clk edge) forces:
  - state=IDLE, address counter=0, latched count=0;
  - rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- Reset takes priority over all other inputs. Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, READ, WAIT, PRESENT, DONE. All outputs are decoded from the registered state and registers; there are no combinational paths from input to output.
- IDLE:
  - busy=0.
  - start=1 latches count and clears the address counter to 0.
  - Next state is DONE if count==0, otherwise READ.
  - start=0 stays in IDLE.
- READ: rd_en=1, rd_addr=address counter. Goes to WAIT unconditionally.
- WAIT:
  - rd_en=0.
  - out_data <= rd_data at the end of this cycle (1-cycle RAM latency).
  - Goes to PRESENT.
- PRESENT:
  - out_valid=1.
  - out_last=1 when address counter == latched count - 1.
  - out_data is held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_valid&out_ready: if the word is last, go to DONE; otherwise increment the address counter and go to READ.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start asserted in any state other than IDLE is ignored; count is not re-sampled.
- count greater than 2^ADDR_W is clamped to 2^ADDR_W.
  - The address counter must never wrap.
  - The counter is ADDR_W+1 bits internally; rd_addr is its low ADDR_W bits.
- Throughput: one word per 3 cycles when out_ready is held high.
  - Latency from start to first out_valid is 3 cycles: the start cycle, READ, WAIT.
- Words leave in strict ascending address order, 0 .. count-1, with no duplicates and no drops.
- out_data keeps its last value in IDLE and DONE. out_valid=0 there.
- rd_en is never asserted outside READ.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert rst during PRESENT of word 2 of a count=5 burst.
  - Response: the next cycle shows all outputs zero and busy=0, with no done pulse. A new start with count=2 then streams addresses 0 and 1 correctly.
- Basic drain:
  - Stimulus: RAM preloaded with addr i = 0x1000_0000+i; start with count=4; out_ready=1.
  - Response: out_data sequence 0x10000000, 0x10000001, 0x10000002, 0x10000003.
  - First out_valid appears 3 cycles after start. out_last is high only on the 4th word. done pulses once, 1 cycle after the 4th acceptance.
- Backpressure:
  - Stimulus: count=3; out_ready low for 5 cycles during word 1.
  - Response: out_valid stays high and out_data stays stable (0x10000001) throughout. No extra rd_en occurs. The stream resumes with word 2 after out_ready rises.
- Zero count:
  - Stimulus: start with count=0.
  - Response: no rd_en and no out_valid. done pulses on the cycle after start. busy is high for that one cycle only.
- Full depth and clamp:
  - Stimulus: ADDR_W=4; start with count=16, then with count=31.
  - Response: both runs emit exactly 16 words at addresses 0..15. rd_addr never wraps to 0 mid-burst. out_last is high on address 15.
- Start ignored while busy:
  - Stimulus: re-pulse start with count=1 during a count=4 burst.
  - Response: the burst completes all 4 words unchanged, with one done pulse.
